mem_port_sched: RTL and testbench

- Schedules the single-port synchronous data/instruction memory between three requesters:
  - CPU instruction fetch, in phase p1.
  - CPU load/store, in phase p4.
  - Host debug/loader port, which reads and writes memory while the CPU runs or is stopped.
- Sits between the phase counter, the CPU datapath and the memory macro.
- CPU accesses are never delayed. The debug port uses idle cycles only, via a four-phase req/ack handshake.

---
 rtl/mem_sched_pkg.sv | 20 ++
 rtl/dbg_handshake.sv | 62 ++++++
 rtl/mem_port_sched.sv | 104 ++++++++++
 tb/tb_mem_port_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and phase indices for the memory port scheduler
package mem_sched_pkg;

   typedef enum logic [1:0] {
      RD_NONE  = 2'd0,
      RD_FETCH = 2'd1,
      RD_DATA  = 2'd2,
      RD_DBG   = 2'd3
   } rd_src_t;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_ACC  = 2'd1,
      D_ACK  = 2'd2
   } dbg_state_t;

   localparam int PH_FETCH = 0;
   localparam int PH_MEM   = 3;

endpackage

// File: rtl/dbg_handshake.sv
// rtl/dbg_handshake.sv - four-phase debug handshake FSM and blocked-cycle counter
module dbg_handshake #(
   parameter int DATA_W = 16,
   parameter int WCNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic              cpu_grant,
   input  logic              clr_stats,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              dbg_grant,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [WCNT_W-1:0] wait_cnt
);
   import mem_sched_pkg::*;

   dbg_state_t state;
   logic       acc_read;

   // Debug only ever takes a cycle the CPU left idle.
   assign dbg_grant = (state == D_IDLE) && dbg_req && !cpu_grant;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= D_IDLE;
         dbg_ack   <= 1'b0;
         dbg_rdata <= '0;
         acc_read  <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            D_IDLE: begin
               if (dbg_grant) begin
                  state    <= D_ACC;
                  acc_read <= !dbg_we;
               end
            end
            D_ACC: begin
               state   <= D_ACK;
               dbg_ack <= 1'b1;
               if (acc_read) dbg_rdata <= mem_rdata;
            end
            D_ACK: begin
               if (!dbg_req) begin
                  state   <= D_IDLE;
                  dbg_ack <= 1'b0;
               end
            end
            default: state <= D_IDLE;
         endcase

         if (clr_stats)
            wait_cnt <= '0;
         else if ((state == D_IDLE) && dbg_req && cpu_grant && (wait_cnt != '1))
            wait_cnt <= wait_cnt + WCNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - single-port memory scheduler: fetch, load/store, debug
module mem_port_sched #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int WCNT_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        phase,
   input  logic [ADDR_W-1:0] pc,
   input  logic              dm_re,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] inst,
   output logic              inst_valid,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              clr_stats,
   output logic [WCNT_W-1:0] wait_cnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import mem_sched_pkg::*;

   logic    fetch_grant;
   logic    data_grant;
   logic    cpu_grant;
   logic    dbg_grant;
   rd_src_t rd_src;
   rd_src_t rd_src_next;
   logic    phase_unused;

   assign phase_unused = ^{phase[4], phase[2:1]};

   // Fetch beats a load/store if a malformed phase vector carries both.
   assign fetch_grant = phase[PH_FETCH];
   assign data_grant  = phase[PH_MEM] && (dm_re || dm_we) && !fetch_grant;
   assign cpu_grant   = fetch_grant || data_grant;

   always_comb begin
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      rd_src_next = RD_NONE;
      if (reset) begin
         if (fetch_grant) begin
            mem_en      = 1'b1;
            mem_addr    = pc;
            rd_src_next = RD_FETCH;
         end else if (data_grant) begin
            mem_en      = 1'b1;
            mem_we      = dm_we;
            mem_addr    = dm_addr;
            mem_wdata   = dm_wdata;
            rd_src_next = dm_we ? RD_NONE : RD_DATA;
         end else if (dbg_grant) begin
            mem_en      = 1'b1;
            mem_we      = dbg_we;
            mem_addr    = dbg_addr;
            mem_wdata   = dbg_wdata;
            rd_src_next = dbg_we ? RD_NONE : RD_DBG;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rd_src <= RD_NONE;
      else        rd_src <= rd_src_next;
   end

   assign inst       = mem_rdata;
   assign load_data  = mem_rdata;
   assign inst_valid = (rd_src == RD_FETCH);
   assign load_valid = (rd_src == RD_DATA);

   dbg_handshake #(
      .DATA_W(DATA_W),
      .WCNT_W(WCNT_W)
   ) u_dbg (
      .clock     (clock),
      .reset     (reset),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .cpu_grant (cpu_grant),
      .clr_stats (clr_stats),
      .mem_rdata (mem_rdata),
      .dbg_grant (dbg_grant),
      .dbg_ack   (dbg_ack),
      .dbg_rdata (dbg_rdata),
      .wait_cnt  (wait_cnt)
   );

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - scoreboard bench for mem_port_sched
module tb_mem_port_sched;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  phase = '0;
   logic [11:0] pc = '0;
   logic        dm_re = 1'b0;
   logic        dm_we = 1'b0;
   logic [11:0] dm_addr = '0;
   logic [15:0] dm_wdata = '0;
   logic [15:0] inst;
   logic        inst_valid;
   logic [15:0] load_data;
   logic        load_valid;
   logic        dbg_req = 1'b0;
   logic        dbg_we = 1'b0;
   logic [11:0] dbg_addr = '0;
   logic [15:0] dbg_wdata = '0;
   logic        dbg_ack;
   logic [15:0] dbg_rdata;
   logic        clr_stats = 1'b0;
   logic [15:0] wait_cnt;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;

   logic [15:0] mem [0:4095];
   logic [15:0] exp_inst[$];
   logic [15:0] exp_load[$];
   logic [15:0] exp_dbg[$];
   int          checks = 0;
   int          failures = 0;
   int          en_cnt = 0;
   int          we_cnt = 0;
   logic        prev_ack = 1'b0;

   mem_port_sched dut (
      .clock(clock), .reset(reset), .phase(phase), .pc(pc),
      .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .inst(inst), .inst_valid(inst_valid), .load_data(load_data), .load_valid(load_valid),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .clr_stats(clr_stats), .wait_cnt(wait_cnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Synchronous single-port memory; preload is reapplied while reset is low.
   always @(posedge clock) begin
      if (!reset) begin
         mem[12'h010] <= 16'h1234;
         mem[12'h123] <= 16'h0ABC;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (mem_en) en_cnt++;
      if (mem_en && mem_we) we_cnt++;
      if (inst_valid) begin
         if (exp_inst.size() == 0) check("inst_unexpected", 32'(inst_valid), 32'd0);
         else check("inst", 32'(inst), 32'(exp_inst.pop_front()));
      end
      if (load_valid) begin
         if (exp_load.size() == 0) check("load_unexpected", 32'(load_valid), 32'd0);
         else check("load_data", 32'(load_data), 32'(exp_load.pop_front()));
      end
      if (dbg_ack && !prev_ack) begin
         if (exp_dbg.size() == 0) check("dbg_ack_unexpected", 32'(dbg_ack), 32'd0);
         else check("dbg_rdata", 32'(dbg_rdata), 32'(exp_dbg.pop_front()));
      end
      prev_ack = dbg_ack;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic dbg_access(input logic we, input logic [11:0] a, input logic [15:0] wd,
                             input logic [4:0] ph0, input int exp_lat, input int hold,
                             input logic [15:0] exp_rd);
      int lat;
      int bad;
      exp_dbg.push_back(exp_rd);
      phase = ph0; dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
      step();
      phase = 5'b0;
      lat = 1;
      while (!dbg_ack && lat < 20) begin
         step();
         lat++;
      end
      check("dbg_ack_latency", 32'(lat), 32'(exp_lat));
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         step();
         if (!dbg_ack) bad++;
      end
      check("dbg_ack_hold", 32'(bad), 32'd0);
      dbg_req = 1'b0;
      step();
      check("dbg_ack_fall", 32'(dbg_ack), 32'd0);
   endtask

   typedef struct {
      logic [4:0] ph;
      logic       re;
   } pvec_t;

   initial begin
      pvec_t pv[6];
      int    e0;
      int    w0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
      check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
      check("rst_wait_cnt", 32'(wait_cnt), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_valids", 32'({inst_valid, load_valid}), 32'd0);
      reset = 1'b1;
      step();

      // Pipelined phases; dm_re held high to show it only matters in p4.
      pv[0] = '{5'b00001, 1'b1}; pv[1] = '{5'b00010, 1'b1}; pv[2] = '{5'b00101, 1'b1};
      pv[3] = '{5'b01000, 1'b1}; pv[4] = '{5'b10010, 1'b1}; pv[5] = '{5'b00001, 1'b1};
      pc = 12'h010; dm_addr = 12'h123;
      e0 = en_cnt;
      for (int i = 0; i < 6; i++) begin
         phase = pv[i].ph; dm_re = pv[i].re;
         if (pv[i].ph[0]) exp_inst.push_back(16'h1234);
         else if (pv[i].ph[3]) exp_load.push_back(16'h0ABC);
         step();
      end
      phase = 5'b0; dm_re = 1'b0;
      check("pipe_mem_en_cycles", 32'(en_cnt - e0), 32'd4);
      step();

      // Store with dm_re also set, then fetch the stored word.
      w0 = we_cnt;
      phase = 5'b01000; dm_we = 1'b1; dm_re = 1'b1; dm_addr = 12'h040; dm_wdata = 16'h5A5A;
      step();
      phase = 5'b00010; dm_we = 1'b0; dm_re = 1'b0;
      step();
      phase = 5'b00001; pc = 12'h040; exp_inst.push_back(16'h5A5A);
      step();
      phase = 5'b0;
      step();
      check("store_we_pulses", 32'(we_cnt - w0), 32'd1);
      check("store_mem_model", 32'(mem[12'h040]), 32'h5A5A);

      // CPU stopped: debug write then read back.
      w0 = we_cnt;
      dbg_access(1'b1, 12'hFFF, 16'hBEEF, 5'b0, 2, 1, 16'h0000);
      check("dbg_write_pulses", 32'(we_cnt - w0), 32'd1);
      dbg_access(1'b0, 12'hFFF, 16'h0000, 5'b0, 2, 1, 16'hBEEF);

      // Debug request collides with a fetch.
      pc = 12'h010; exp_inst.push_back(16'h1234);
      dbg_access(1'b0, 12'hFFF, 16'h0000, 5'b00001, 3, 0, 16'hBEEF);
      check("wait_cnt_one", 32'(wait_cnt), 32'd1);
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      check("wait_cnt_clr", 32'(wait_cnt), 32'd0);

      // Request held long after ack: still a single memory access.
      e0 = en_cnt;
      dbg_access(1'b0, 12'h123, 16'h0000, 5'b0, 2, 5, 16'h0ABC);
      check("hold_single_access", 32'(en_cnt - e0), 32'd1);

      // Reset asserted while the FSM sits in D_ACC.
      phase = 5'b00001; pc = 12'h010; exp_inst.push_back(16'h1234);
      dbg_we = 1'b1; dbg_addr = 12'h200; dbg_wdata = 16'h1111; dbg_req = 1'b1;
      step();
      phase = 5'b0;
      step();
      check("pre_rst_wait_cnt", 32'(wait_cnt), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_dbg_ack", 32'(dbg_ack), 32'd0);
      check("mid_rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
      check("mid_rst_wait_cnt", 32'(wait_cnt), 32'd0);
      check("mid_rst_mem_en", 32'(mem_en), 32'd0);
      check("dbg_write_landed", 32'(mem[12'h200]), 32'h1111);
      dbg_req = 1'b0;
      w0 = we_cnt;
      step();
      step();
      reset = 1'b1;
      repeat (4) step();
      check("post_rst_no_write", 32'(we_cnt - w0), 32'd0);
      check("post_rst_dbg_ack", 32'(dbg_ack), 32'd0);

      check("inst_queue_drained", 32'(exp_inst.size()), 32'd0);
      check("load_queue_drained", 32'(exp_load.size()), 32'd0);
      check("dbg_queue_drained", 32'(exp_dbg.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
